fdt_programmable: RTL and testbench
===================================

Name: fdt_programmable

Overview:
Parametrised frame delay time (FDT) generator for the PICC transmit path in ISO/IEC 14443-3 Type A.
- Times the interval from the last rising edge of the synchronised PCD pause to the PICC response start, per section 6.2.1.1: FDT = n*128 + 84 carrier ticks when the last Rx bit is 1, and n*128 + 20 when it is 0.
- Extends the fixed n=9 FDT block with a runtime-selectable n, minimum-n clamping, enable/cancel control, and elapsed/busy status outputs.
- Sits between the Rx synchroniser/decoder and the Tx framing logic.

Parameters:
N_WIDTH, 8, width of fdt_n input; max n = 2^N_WIDTH-1
N_MIN, 9, minimum legal n; smaller fdt_n values are clamped up to N_MIN
TIMING_ADJUST, 0, ticks subtracted from every target to compensate downstream pipeline latency (must be < N_MIN*128+20)

Ports:
clk  input  1  carrier-derived clock, one tick per carrier period
rst_n  input  1  synchronous active-low reset
en  input  1  block enable; low forces IDLE and ignores pauses
pause_n_synchronised  input  1  synchronised pause detector, low during a pause
last_rx_bit  input  1  value of last received bit, selects +84 (1) or +20 (0)
fdt_n  input  N_WIDTH  FDT slot count n
cancel  input  1  abort the pending FDT, return to IDLE
trigger  output  1  single-cycle pulse when FDT expires
elapsed  output  1  level, high from trigger until next pause/cancel/disable
counting  output  1  level, high while an FDT is in progress

Behaviour:
- Reset (rst_n low, sampled on posedge clk): state IDLE, counter 0, trigger=0, elapsed=0, counting=0. trigger must never be high while rst_n is low.
- Widths:
  - n_eff = max(fdt_n, N_MIN).
  - target = n_eff*128 + (last_rx_bit ? 84 : 20) - TIMING_ADJUST.
  - Counter width = $clog2((2^N_WIDTH-1)*128+85); no overflow is possible.
- Rising-edge detect: a registered copy of pause_n_synchronised is kept; rise = current high and previous low.
- States:
  - IDLE:
    - rise with en=1 and cancel=0 -> COUNTING, counter cleared.
  - COUNTING:
    - counter increments every cycle.
    - Any new rise restarts the counter at 0 and stays in COUNTING. Multiple pauses per frame are normal; only the last one matters.
    - A pause falling edge alone does not stop counting.
    - When the counter reaches target-1 (comparison is >=): trigger pulses for 1 cycle, elapsed is set, and the state goes to ELAPSED.
  - ELAPSED:
    - Holds with elapsed=1.
    - pause_n_synchronised going low clears elapsed and returns to IDLE; the subsequent rise re-arms the block.
    - A rise seen in the same cycle re-arms directly to COUNTING.
- Timing: the trigger rising edge occurs exactly target clock periods after the clock edge following the rising edge of pause_n_synchronised. With n=9 this matches the legacy block: 1172-TIMING_ADJUST ticks for last bit 0 and 1236-TIMING_ADJUST for last bit 1.
- Target evaluation:
  - last_rx_bit and fdt_n are evaluated combinationally every cycle while COUNTING; they may change after the pause (decoder settles late).
  - If target drops to or below the current count, trigger fires on the next cycle, exactly once.
- Priority, per cycle, highest first: rst_n, then en=0, then cancel, then rise.
  - cancel or en=0 -> IDLE, counter 0, elapsed=0, no trigger, including in the cycle where the match would occur.
- counting = (state == COUNTING). trigger, elapsed and counting are registered outputs.
- No trigger is ever generated without a preceding rise; the block is not free-running.

Test Plan:
- Reset 5 cycles, en=1, no pause for 3000 cycles -> trigger never asserted, elapsed=0, counting=0.
- TIMING_ADJUST=13, fdt_n=9, last_rx_bit=0, 5-cycle pause -> trigger exactly 1159 cycles after the rise. Repeat with last_rx_bit=1 -> 1223 cycles. elapsed stays high until the next pause.
- fdt_n=20, last_rx_bit=1 -> trigger at 2644-13=2631 cycles. fdt_n=3 -> clamped to 9, trigger at 1159/1223.
- Random 1-5 pauses spaced 1-1000 cycles apart, last_rx_bit random per pause -> exactly one trigger, timed from the final rise using the final last_rx_bit.
- Mid-count checks:
  - fdt_n 20->9 at count 1500 -> trigger next cycle, once.
  - cancel at count 500 -> no trigger within 3000 cycles, counting=0.
  - en=0 during pause -> no trigger.
- rst_n low at count 800 for 3 cycles -> all outputs 0, no trigger afterwards until a new pause. The assertion that trigger is low whenever rst_n is low is checked throughout.

Source files
------------

// File: rtl/fdt_programmable.sv
// Frame delay time generator for the ISO/IEC 14443-3 Type A PICC transmit path.
// Measures from the last rising edge of the synchronised PCD pause to the start
// of the PICC response: n_eff*128 + (84 | 20) - TIMING_ADJUST carrier ticks.
// n is selectable at runtime and clamped up to N_MIN. The block never runs
// freely: every trigger needs a preceding pause rising edge.
module fdt_programmable #(
  parameter int N_WIDTH       = 8,
  parameter int N_MIN         = 9,
  parameter int TIMING_ADJUST = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               pause_n_synchronised,
  input  logic               last_rx_bit,
  input  logic [N_WIDTH-1:0] fdt_n,
  input  logic               cancel,
  output logic               trigger,
  output logic               elapsed,
  output logic               counting
);

  // The counter can hold the largest possible target, so it never wraps.
  // The target gets one spare bit so that target-1 never underflows.
  localparam int CNT_W = $clog2(((2 ** N_WIDTH) - 1) * 128 + 85);
  localparam int TGT_W = CNT_W + 1;
  localparam logic [N_WIDTH-1:0] N_MIN_V = N_WIDTH'(N_MIN);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_ELAPSED  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pause_prev_q;
  logic               trigger_q, trigger_d;
  logic               elapsed_q, elapsed_d;
  logic               counting_q, counting_d;
  logic               rise_s;
  logic               match_s;
  logic [N_WIDTH-1:0] n_eff_s;
  logic [TGT_W-1:0]   target_s;

  // Pause rising edge, and a target that tracks late changes of last_rx_bit and fdt_n
  always_comb begin
    rise_s   = pause_n_synchronised & ~pause_prev_q;
    n_eff_s  = (fdt_n < N_MIN_V) ? N_MIN_V : fdt_n;
    target_s = TGT_W'(n_eff_s) * TGT_W'(128)
             + (last_rx_bit ? TGT_W'(84) : TGT_W'(20))
             - TGT_W'(TIMING_ADJUST);
    // Using >= rather than == lets a target that drops below the count fire once
    match_s  = ({1'b0, count_q} >= (target_s - TGT_W'(1)));
  end

  // Next-state and output decode; disable and cancel outrank a pause edge
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    trigger_d = 1'b0;
    elapsed_d = elapsed_q;
    if (!en || cancel) begin
      state_d   = ST_IDLE;
      count_d   = '0;
      elapsed_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          count_d   = '0;
          elapsed_d = 1'b0;
          if (rise_s) begin
            state_d = ST_COUNTING;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_COUNTING: begin
          if (rise_s) begin
            // A later pause in the same frame restarts the measurement
            count_d = '0;
          end else if (match_s) begin
            trigger_d = 1'b1;
            elapsed_d = 1'b1;
            count_d   = '0;
            state_d   = ST_ELAPSED;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        ST_ELAPSED: begin
          count_d = '0;
          if (rise_s) begin
            state_d   = ST_COUNTING;
            elapsed_d = 1'b0;
          end else if (!pause_n_synchronised) begin
            state_d   = ST_IDLE;
            elapsed_d = 1'b0;
          end else begin
            state_d = ST_ELAPSED;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          count_d   = '0;
          elapsed_d = 1'b0;
        end
      endcase
    end
    counting_d = (state_d == ST_COUNTING);
  end

  // State, counter, edge-detect history and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      // Starting high stops a pin that is already high from reading as a rise
      pause_prev_q <= 1'b1;
      trigger_q    <= 1'b0;
      elapsed_q    <= 1'b0;
      counting_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      pause_prev_q <= pause_n_synchronised;
      trigger_q    <= trigger_d;
      elapsed_q    <= elapsed_d;
      counting_q   <= counting_d;
    end
  end

  assign trigger  = trigger_q;
  assign elapsed  = elapsed_q;
  assign counting = counting_q;

endmodule

// File: tb/tb_fdt_programmable.sv
// Self-checking bench for fdt_programmable (TIMING_ADJUST = 13).
module tb_fdt_programmable;

  localparam int N_MIN = 9;
  localparam int TA    = 13;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       pause_n = 1'b1;
  logic       last_rx_bit = 1'b0;
  logic       cancel = 1'b0;
  logic [7:0] fdt_n = 8'd9;
  logic       trigger, elapsed, counting;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int trig_count = 0;
  int last_trig = 0;
  int rise_edge = 0;

  typedef struct {
    int n;
    bit b;
    int exp;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  fdt_programmable #(
    .N_WIDTH(8),
    .N_MIN(N_MIN),
    .TIMING_ADJUST(TA)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .pause_n_synchronised(pause_n),
    .last_rx_bit(last_rx_bit),
    .fdt_n(fdt_n),
    .cancel(cancel),
    .trigger(trigger),
    .elapsed(elapsed),
    .counting(counting)
  );

  // Edge counter: cyc equals the index of the most recent rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // Trigger monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (trigger) begin
      trig_count = trig_count + 1;
      last_trig  = cyc;
    end
  end

  // Reference: delay from the edge that sees the rise to the trigger edge
  function automatic int exp_delay(input int n, input bit b);
    int ne;
    ne = (n < N_MIN) ? N_MIN : n;
    return ne * 128 + (b ? 84 : 20) - TA;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Advance n edges; while rst_n is low, trigger must stay low
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (!rst_n) check("trig_in_reset", int'(trigger), 0);
    end
  endtask

  task automatic do_pause(input int len);
    pause_n = 1'b0;
    step(len);
    pause_n = 1'b1;
    rise_edge = cyc + 1;
  endtask

  task automatic step_to_count(input int k);
    if (rise_edge + k > cyc) step(rise_edge + k - cyc);
  endtask

  task automatic wait_trig(input int base, input int budget);
    for (int i = 0; i < budget && trig_count == base; i++) step(1);
  endtask

  task automatic run_frame(input int n, input bit b, input int exp);
    int base;
    base = trig_count;
    fdt_n = 8'(n);
    last_rx_bit = b;
    do_pause(5);
    wait_trig(base, exp + 20);
    check("frame_delay", last_trig - rise_edge, exp);
    step(20);
    check("frame_once", trig_count - base, 1);
    check("frame_elapsed", int'(elapsed), 1);
    check("frame_counting", int'(counting), 0);
  endtask

  initial begin
    int base;
    int np;
    int n;
    bit b;

    tbl[0] = '{9, 1'b0, 1159};
    tbl[1] = '{9, 1'b1, 1223};
    tbl[2] = '{20, 1'b1, 2631};
    tbl[3] = '{3, 1'b0, 1159};
    tbl[4] = '{3, 1'b1, 1223};
    tbl[5] = '{10, 1'b0, 1287};
    tbl[6] = '{0, 1'b1, 1223};

    // Reset, then idle with en=1 and no pause
    rst_n = 1'b0;
    en = 1'b1;
    step(5);
    rst_n = 1'b1;
    step(1);
    check("rst_trigger", int'(trigger), 0);
    check("rst_elapsed", int'(elapsed), 0);
    check("rst_counting", int'(counting), 0);
    base = trig_count;
    step(3000);
    check("idle_no_trig", trig_count - base, 0);
    check("idle_elapsed", int'(elapsed), 0);
    check("idle_counting", int'(counting), 0);

    // Table of single-pause frames
    foreach (tbl[i]) run_frame(tbl[i].n, tbl[i].b, tbl[i].exp);

    // elapsed holds until a pause, then drops; the following rise re-arms
    step(200);
    check("elapsed_hold", int'(elapsed), 1);
    pause_n = 1'b0;
    step(1);
    check("elapsed_clr", int'(elapsed), 0);
    check("elapsed_clr_cnt", int'(counting), 0);
    step(2);
    base = trig_count;
    pause_n = 1'b1;
    rise_edge = cyc + 1;
    step(1);
    check("rearm_counting", int'(counting), 1);
    wait_trig(base, 1300);
    check("rearm_delay", last_trig - rise_edge, exp_delay(0, 1'b1));

    // Randomised multi-pause frames: only the last rise and last bit count
    for (int it = 0; it < 6; it++) begin
      np = $urandom_range(5, 1);
      n = $urandom_range(12, 0);
      b = 1'b0;
      base = trig_count;
      fdt_n = 8'(n);
      for (int p = 0; p < np; p++) begin
        b = 1'($urandom_range(1, 0));
        last_rx_bit = b;
        do_pause($urandom_range(5, 1));
        if (p != np - 1) step($urandom_range(1000, 1));
      end
      check("rand_early", trig_count - base, 0);
      wait_trig(base, exp_delay(n, b) + 20);
      check("rand_delay", last_trig - rise_edge, exp_delay(n, b));
      step(5);
      check("rand_once", trig_count - base, 1);
    end

    // fdt_n drops 20 -> 9 at count 1500: trigger on the next edge, once
    base = trig_count;
    fdt_n = 8'd20;
    last_rx_bit = 1'b0;
    do_pause(5);
    step_to_count(1500);
    check("drop_no_trig_yet", trig_count - base, 0);
    fdt_n = 8'd9;
    wait_trig(base, 10);
    check("drop_delay", last_trig - rise_edge, 1501);
    step(50);
    check("drop_once", trig_count - base, 1);

    // cancel at count 500
    base = trig_count;
    do_pause(5);
    step_to_count(500);
    check("cancel_pre_cnt", int'(counting), 1);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    check("cancel_counting", int'(counting), 0);
    step(3000);
    check("cancel_no_trig", trig_count - base, 0);
    check("cancel_elapsed", int'(elapsed), 0);

    // cancel in the very cycle the match would occur
    base = trig_count;
    do_pause(5);
    step_to_count(exp_delay(9, 1'b0) - 1);
    check("cmatch_pre_cnt", int'(counting), 1);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    step(100);
    check("cmatch_no_trig", trig_count - base, 0);
    check("cmatch_counting", int'(counting), 0);

    // en low across a pause: the rise is ignored
    base = trig_count;
    en = 1'b0;
    do_pause(5);
    step(1300);
    check("dis_no_trig", trig_count - base, 0);
    check("dis_counting", int'(counting), 0);
    en = 1'b1;
    step(100);
    check("dis_after_trig", trig_count - base, 0);
    check("dis_after_cnt", int'(counting), 0);

    // reset at count 800 for 3 cycles
    base = trig_count;
    do_pause(5);
    step_to_count(800);
    rst_n = 1'b0;
    step(3);
    check("mrst_trigger", int'(trigger), 0);
    check("mrst_elapsed", int'(elapsed), 0);
    check("mrst_counting", int'(counting), 0);
    rst_n = 1'b1;
    step(1500);
    check("mrst_no_trig", trig_count - base, 0);
    check("mrst_counting2", int'(counting), 0);

    // A fresh pause after reset works normally
    run_frame(9, 1'b1, 1223);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
